// File: rtl/assert_arb_pkg.sv
// Shared types and helpers for the assertion event arbiter.
//   arb_state_e : arbitration state (RUN, HALT)
//   log_rec_t   : log record {id, pass, data} at the default build widths
//   id_width()  : requester index width, max(1, clog2(n))
package assert_arb_pkg;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } arb_state_e;

  localparam int unsigned LOG_ID_W   = 2;
  localparam int unsigned LOG_DATA_W = 16;

  typedef struct packed {
    logic [LOG_ID_W-1:0]   id;
    logic                  pass;
    logic [LOG_DATA_W-1:0] data;
  } log_rec_t;

  function automatic int unsigned id_width(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/assert_event_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant from req starting at the pointer.
//   clk, reset_n : clock, async active-low reset
//   clear        : returns the pointer to 0
//   en           : grant enable (gnt_c is zero when low)
//   req          : request vector
//   gnt_c        : combinational one-hot grant
module rr_arbiter
  import assert_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt_c
);

  localparam int unsigned PTR_W = id_width(N_REQ);

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] gnt_idx;
  logic             found;

  // Search from the pointer upward, wrapping at N_REQ-1.
  always_comb begin
    int unsigned j;
    gnt_c   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    j       = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      j = 32'(ptr_q) + i;
      if (j >= N_REQ) j = j - N_REQ;
      if (!found && en && req[PTR_W'(j)]) begin
        gnt_c[PTR_W'(j)] = 1'b1;
        gnt_idx          = PTR_W'(j);
        found            = 1'b1;
      end
    end

    ptr_d = ptr_q;
    if (clear) begin
      ptr_d = '0;
    end else if (found) begin
      ptr_d = (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

endmodule

// File: rtl/assert_event_arbiter.sv
// Round-robin arbiter sharing one assertion-report slot between N_REQ
// monitors, with saturating pass/fail totals and optional halt on fail.
//   clk, reset_n        : clock, async active-low reset
//   clear               : sync clear of counters, halt state and rr pointer
//   ev_valid/pass/data  : per-requester event inputs
//   ev_ready            : combinational one-hot grant
//   log_valid/ready     : output slot handshake
//   log_id/pass/data    : registered slot contents
//   pass_cnt, fail_cnt  : saturating accepted-event totals
//   halted              : HALT state indicator
module assert_event_arbiter
  import assert_arb_pkg::*;
#(
  parameter  int unsigned N_REQ         = 4,
  parameter  int unsigned DATA_W        = 16,
  parameter  int unsigned CNT_W         = 16,
  parameter  int unsigned FATAL_ON_FAIL = 1,
  localparam int unsigned ID_W          = id_width(N_REQ)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clear,
  input  logic [N_REQ-1:0]        ev_valid,
  input  logic [N_REQ-1:0]        ev_pass,
  input  logic [N_REQ*DATA_W-1:0] ev_data,
  output logic [N_REQ-1:0]        ev_ready,
  output logic                    log_valid,
  input  logic                    log_ready,
  output logic [ID_W-1:0]         log_id,
  output logic                    log_pass,
  output logic [DATA_W-1:0]       log_data,
  output logic [CNT_W-1:0]        pass_cnt,
  output logic [CNT_W-1:0]        fail_cnt,
  output logic                    halted
);

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic              pass;
    logic [DATA_W-1:0] data;
  } slot_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  slot_t            slot_q, slot_d, sel_c;
  logic             log_valid_q, log_valid_d;
  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  arb_state_e       state_q, state_d;

  logic             slot_free_c;
  logic             arb_en_c;
  logic             accept_c;
  logic [N_REQ-1:0] gnt_c;

  assign slot_free_c = !log_valid_q || log_ready;
  // reset_n in the enable keeps ev_ready low while reset is held.
  assign arb_en_c    = reset_n && !clear && (state_q == ST_RUN) && slot_free_c;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .en      (arb_en_c),
    .req     (ev_valid),
    .gnt_c   (gnt_c)
  );

  assign ev_ready = gnt_c;
  assign accept_c = |gnt_c;

  // Mux the granted requester's event into a slot record.
  always_comb begin
    sel_c = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt_c[i]) begin
        sel_c.id   = ID_W'(i);
        sel_c.pass = ev_pass[i];
        sel_c.data = ev_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Slot, counters and RUN/HALT next state.
  always_comb begin
    log_valid_d = log_valid_q;
    slot_d      = slot_q;
    pass_cnt_d  = pass_cnt_q;
    fail_cnt_d  = fail_cnt_q;
    state_d     = state_q;

    if (accept_c) begin
      log_valid_d = 1'b1;
      slot_d      = sel_c;
    end else if (log_ready) begin
      log_valid_d = 1'b0;
    end

    if (clear) begin
      pass_cnt_d = '0;
      fail_cnt_d = '0;
    end else if (accept_c) begin
      if (sel_c.pass) begin
        if (pass_cnt_q != CNT_MAX) pass_cnt_d = pass_cnt_q + CNT_W'(1);
      end else begin
        if (fail_cnt_q != CNT_MAX) fail_cnt_d = fail_cnt_q + CNT_W'(1);
      end
    end

    case (state_q)
      ST_RUN:  if (accept_c && !sel_c.pass && (FATAL_ON_FAIL != 0)) state_d = ST_HALT;
      ST_HALT: if (clear) state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      log_valid_q <= 1'b0;
      slot_q      <= '0;
      pass_cnt_q  <= '0;
      fail_cnt_q  <= '0;
      state_q     <= ST_RUN;
    end else begin
      log_valid_q <= log_valid_d;
      slot_q      <= slot_d;
      pass_cnt_q  <= pass_cnt_d;
      fail_cnt_q  <= fail_cnt_d;
      state_q     <= state_d;
    end
  end

  assign log_valid = log_valid_q;
  assign log_id    = slot_q.id;
  assign log_pass  = slot_q.pass;
  assign log_data  = slot_q.data;
  assign pass_cnt  = pass_cnt_q;
  assign fail_cnt  = fail_cnt_q;
  assign halted    = (state_q == ST_HALT);

endmodule

// File: doc/assert_event_arbiter.md
Name: assert_event_arbiter

Overview:
- Shares a single assertion-report channel between N_REQ assertion monitors, each of which raises pass/fail events.
- Arbitrates events round-robin into one registered output slot and keeps saturating pass/fail totals.
- Optionally halts arbitration on the first failure (fatal mode).
- Sits between the per-property checkers and the log/trace sink.

Parameters:
- N_REQ, 4, number of requesting monitors (2..16)
- DATA_W, 16, event payload width
- CNT_W, 16, width of pass/fail counters
- FATAL_ON_FAIL, 1, 1 = enter HALT after accepting a fail event

Ports:
- clk  in  1  clock, all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous clear of counters, halt state and rr pointer
- ev_valid  in  N_REQ  per-requester event valid
- ev_pass  in  N_REQ  per-requester result, 1 = pass, 0 = fail
- ev_data  in  N_REQ*DATA_W  per-requester payload, requester i at [i*DATA_W +: DATA_W]
- ev_ready  out  N_REQ  one-hot grant; event accepted when ev_valid[i] & ev_ready[i]
- log_valid  out  1  output slot holds an event
- log_ready  in  1  sink accepts the slot
- log_id  out  ID_W  requester index, ID_W = max(1, clog2(N_REQ))
- log_pass  out  1  result of the slot event
- log_data  out  DATA_W  payload of the slot event
- pass_cnt  out  CNT_W  accepted pass events, saturating
- fail_cnt  out  CNT_W  accepted fail events, saturating
- halted  out  1  HALT state indicator

Behaviour:
- Reset values (reset_n low, async): log_valid=0, log_id=0, log_pass=0, log_data=0, pass_cnt=0, fail_cnt=0, halted=0, rr pointer=0, state=RUN. ev_ready=0 during reset.
- Slot free condition: slot_free = !log_valid | log_ready.
- Grant:
  - ev_ready is combinational from ev_valid, the rr pointer, state, clear and slot_free.
  - At most one bit of ev_ready is set, and only for a valid requester.
  - No grant while clear=1, while state=HALT, or while slot_free=0.
- Priority: round-robin. Search starts at the rr pointer and wraps from N_REQ-1 to 0. After a grant to index k, the pointer becomes (k+1) mod N_REQ. The pointer is unchanged when there is no grant.
- Latency: an accepted event appears on log_* the next cycle. Back-to-back throughput is 1 event per cycle when log_ready stays 1.
- Output slot:
  - log_* are registered and stay stable while log_valid=1 and log_ready=0.
  - A handshake with no new grant clears log_valid the next cycle.
  - A handshake in the same cycle as a new grant loads the new event with log_valid kept at 1.
- Counters:
  - pass_cnt increments on each accepted event with ev_pass=1; fail_cnt increments on each accepted event with ev_pass=0.
  - Both counters stick at 2^CNT_W-1 and never wrap.
- State machine:
  - RUN -> HALT when a fail event is accepted and FATAL_ON_FAIL=1; halted=1 from the next cycle.
  - HALT -> RUN on clear.
  - In HALT the slot still drains normally, and no new grants are issued.
  - With FATAL_ON_FAIL=0 the block never leaves RUN.
- clear:
  - Zeroes both counters, sets the rr pointer to 0 and sets state to RUN.
  - Blocks grants in that cycle, so clear and an accept never coincide.
  - Does not touch the output slot; a pending event still drains.
- Requesters hold ev_valid/ev_pass/ev_data until granted. The arbiter does not check this.
- Reset mid-operation: any pending slot event is discarded, and counters and state return to reset values immediately (async).

Decomposition:
- Package assert_arb_pkg holds:
  - state enum (RUN, HALT)
  - typedef of the log record struct {id, pass, data}
  - function for the ID_W computation
- One sub-module, rr_arbiter: parameterized N_REQ, combinational one-hot grant from a request vector and pointer, plus the registered pointer update on grant.
- Counters, slot and FSM stay in the top.

Test Plan:
1. Reset check: hold reset_n=0 with all ev_valid=1 -> ev_ready=0, log_valid=0, pass_cnt=fail_cnt=0, halted=0. Release reset_n -> the first grant goes to requester 0.
2. Fairness: all 4 requesters valid, all pass, data = 16'h0A00+i, log_ready=1 -> log_id sequence 0,1,2,3,0… on consecutive cycles with no bubbles. After 8 events pass_cnt=8.
3. Backpressure: slot full, log_ready=0 for 5 cycles -> log_* stable, ev_ready=0 throughout. Raise log_ready -> the slot drains and the next requester is granted in the same cycle.
4. Fatal: FATAL_ON_FAIL=1, requester 2 sends a fail with data 16'hDEAD -> fail_cnt=1, halted=1 next cycle, the DEAD event still drains, further ev_valid gets no grant. Pulse clear -> halted=0, counters 0, grants resume starting at index 0.
5. Saturation: CNT_W=4, send 20 pass events -> pass_cnt stops at 15.
6. Async reset mid-stream: assert reset_n low while log_valid=1 and log_ready=0 -> log_valid drops immediately and counters read 0 with no clock edge.
